// File: rtl/vx_smem_pkg.sv
// Shared configuration and types for the banked shared-memory responder:
// geometry constants, lane request / response beat structs and a credit helper.
package vx_smem_pkg;

  localparam int NUM_REQS   = 4;
  localparam int NUM_BANKS  = 4;
  localparam int BANK_WORDS = 256;
  localparam int ADDR_W     = 30;
  localparam int TAG_W      = 4;
  localparam int RSP_DEPTH  = 4;

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = $clog2(BANK_WORDS);
  localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

  typedef logic [BANK_W-1:0] bank_idx_t;
  typedef logic [ROW_W-1:0]  row_idx_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        byteen;
    logic [31:0]       data;
    logic [TAG_W-1:0]  tag;
  } lane_req_t;

  typedef struct packed {
    logic [NUM_REQS-1:0]       mask;
    logic [NUM_REQS-1:0][31:0] data;
    logic [TAG_W-1:0]          tag;
  } rsp_beat_t;

  // A new read beat may start only while queued plus in-flight beats leave a free slot.
  function automatic logic credit_avail(input logic [CNT_W-1:0] occupancy,
                                        input logic [CNT_W-1:0] inflight);
    logic [CNT_W:0] total;
    total = {1'b0, occupancy} + {1'b0, inflight};
    return total < (CNT_W + 1)'(RSP_DEPTH);
  endfunction

endpackage

// File: rtl/vx_smem_rsp_fifo.sv
// Fall-through FIFO of response beats: an incoming beat is visible on the head
// in the same cycle when the FIFO is empty, and is only stored if not taken at once.
module vx_smem_rsp_fifo
  import vx_smem_pkg::*;
#(
  parameter int DEPTH = RSP_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  rsp_beat_t                    push_beat,
  input  logic                         pop,
  output rsp_beat_t                    head,
  output logic                         head_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  rsp_beat_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             store;
  logic             take;

  // NOTE: every always_comb output gets a value on all paths so no latch is inferred.
  always_comb begin
    empty      = (count == '0);
    full       = (count == CW'(DEPTH));
    head_valid = !empty || push;
    head       = empty ? push_beat : mem[rd_ptr];
    store      = push && !(empty && pop);
    take       = pop && !empty;
  end

  // NOTE: beat storage has no reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= push_beat;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (take)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(store) - CW'(take);
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full && !pop)) else $error("rsp fifo push while full");
      assert (!(pop && !head_valid)) else $error("rsp fifo pop while empty");
    end
  end
`endif

endmodule

// File: rtl/vx_smem_responder.sv
// Banked shared-memory slave for per-lane LSU requests: fixed-priority bank
// arbitration, one-tag read beats, a one-stage read pipeline and credit-limited FIFO.
module vx_smem_responder
  import vx_smem_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        req_valid,
  input  logic [NUM_REQS-1:0]        req_rw,
  input  logic [NUM_REQS*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQS*4-1:0]      req_byteen,
  input  logic [NUM_REQS*32-1:0]     req_data,
  input  logic [NUM_REQS*TAG_W-1:0]  req_tag,
  output logic [NUM_REQS-1:0]        req_ready,
  output logic [NUM_REQS-1:0]        rsp_valid,
  output logic [NUM_REQS*32-1:0]     rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  input  logic                       rsp_ready
);

  lane_req_t           lane_req  [NUM_REQS];
  bank_idx_t           lane_bank [NUM_REQS];
  row_idx_t            lane_row  [NUM_REQS];
  logic                addr_unused;

  logic [NUM_REQS-1:0] win;
  logic [NUM_REQS-1:0] rd_fire;
  logic [NUM_REQS-1:0] wr_fire;
  logic                lead_found;
  logic [TAG_W-1:0]    lead_tag;
  logic                credit_ok;

  logic [NUM_BANKS-1:0] bank_rd_en;
  row_idx_t             bank_rd_row [NUM_BANKS];
  logic [31:0]          sram        [NUM_BANKS][BANK_WORDS];
  logic [31:0]          bank_rdata  [NUM_BANKS];

  logic                s1_valid;
  logic [NUM_REQS-1:0] s1_mask;
  logic [TAG_W-1:0]    s1_tag;
  bank_idx_t           s1_bank [NUM_REQS];
  logic [CNT_W-1:0]    inflight;

  rsp_beat_t           push_beat;
  rsp_beat_t           head;
  logic                head_valid;
  logic                pop;
  logic [CNT_W-1:0]    fifo_count;

  always_comb begin
    addr_unused = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      lane_req[i].rw     = req_rw[i];
      lane_req[i].addr   = req_addr[i*ADDR_W +: ADDR_W];
      lane_req[i].byteen = req_byteen[i*4 +: 4];
      lane_req[i].data   = req_data[i*32 +: 32];
      lane_req[i].tag    = req_tag[i*TAG_W +: TAG_W];
      lane_bank[i]       = lane_req[i].addr[BANK_W-1:0];
      lane_row[i]        = lane_req[i].addr[BANK_W +: ROW_W];
      // Address bits above the bank/row fields alias onto the same word.
      addr_unused        = addr_unused ^ (^lane_req[i].addr[ADDR_W-1:BANK_W+ROW_W]);
    end
  end

  // Lowest-index valid lane per bank wins; reads then narrow to the lead tag under credit.
  always_comb begin
    win        = '0;
    lead_found = 1'b0;
    lead_tag   = '0;
    req_ready  = '0;
    credit_ok  = credit_avail(fifo_count, inflight);
    for (int i = 0; i < NUM_REQS; i++) begin
      win[i] = req_valid[i];
      for (int j = 0; j < NUM_REQS; j++) begin
        if (j < i && req_valid[j] && lane_bank[j] == lane_bank[i]) win[i] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!lead_found && win[i] && !lane_req[i].rw) begin
        lead_found = 1'b1;
        lead_tag   = lane_req[i].tag;
      end
    end
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = win[i] && (lane_req[i].rw || (credit_ok && lane_req[i].tag == lead_tag));
    end
    rd_fire = req_ready & ~req_rw;
    wr_fire = req_ready & req_rw;
  end

  always_comb begin
    bank_rd_en = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_rd_row[b] = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rd_fire[i]) begin
        bank_rd_en[lane_bank[i]]  = 1'b1;
        bank_rd_row[lane_bank[i]] = lane_row[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (wr_fire[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (lane_req[i].byteen[b])
            sram[lane_bank[i]][lane_row[i]][b*8 +: 8] <= lane_req[i].data[b*8 +: 8];
        end
      end
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_rd_en[b]) bank_rdata[b] <= sram[b][bank_rd_row[b]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      inflight <= '0;
    end else begin
      s1_valid <= |rd_fire;
      s1_mask  <= rd_fire;
      s1_tag   <= lead_tag;
      for (int i = 0; i < NUM_REQS; i++) s1_bank[i] <= lane_bank[i];
      inflight <= inflight + CNT_W'(|rd_fire) - CNT_W'(s1_valid);
    end
  end

  always_comb begin
    push_beat.mask = s1_mask;
    push_beat.tag  = s1_tag;
    for (int i = 0; i < NUM_REQS; i++) push_beat.data[i] = bank_rdata[s1_bank[i]];
  end

  assign pop = head_valid && rsp_ready;

  vx_smem_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (s1_valid),
    .push_beat  (push_beat),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (fifo_count)
  );

  assign rsp_valid = head_valid ? head.mask : '0;
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;

endmodule
